bike_motion_engine: RTL and testbench
=====================================

# bike_motion_engine

Per-player bike movement engine feeding the VGA renderer's bike position/orientation inputs and consuming its crash flag. It advances one bike's 30x30 sprite top-left address across the 640x480 playfield once every FRAMES_PER_MOVE frames, applies controller turn requests (rejecting reversals), clamps at screen edges, and freezes the bike on crash. One instance per player; frame timing is derived from the renderer's registered vertical sync, in the same iVGA_CLK domain.

## Interface
- START_X, 19'd100: initial sprite top-left column.
- START_Y, 19'd100: initial sprite top-left row.
- START_DIR, 2'd3: initial direction (0 up, 1 down, 2 left, 3 right).
- STEP, 4'd2: pixels moved per move event.
- FRAMES_PER_MOVE, 4'd1: frames between move events (1..15).
- iVGA_CLK  in  1  pixel clock; all logic on rising edge.
- iRST_n  in  1  asynchronous, active-low reset.
- iVS  in  1  vertical sync from renderer, active low.
- go  in  1  level; starts play from IDLE.
- reset_round  in  1  synchronous; returns to IDLE at start position.
- dir_req  in  4  one-hot-ish {up,down,left,right} = bits [3:0]; priority up>down>left>right.
- crash  in  1  renderer crash flag (may pulse for single pixels).
- bike_addr  out  32  linear address row*640+col of sprite top-left.
- bike_orient  out  32  signed per-move address delta: up -640*STEP, down +640*STEP, left -STEP, right +STEP.
- dir  out  2  current direction code.
- crashed  out  1  high in CRASHED.
- move_strobe  out  1  one-cycle pulse on each position update.

## Operation
- Internal x (10b), y (9b); bike_addr = y*640 + x, zero-extended to 32b, registered.
- Frame tick: vs_q registers iVS; tick = vs_q & ~iVS (falling edge), one cycle per frame.
- frame_cnt counts ticks 0..FRAMES_PER_MOVE-1; move event on tick when frame_cnt == FRAMES_PER_MOVE-1, then frame_cnt wraps to 0.
- pending_dir: any cycle with dir_req != 0 latches highest-priority requested direction; last request before a move event wins. Request opposite to current dir (0<->1, 2<->3) or equal to it is ignored.
- crash_seen: sticky, set on any cycle crash=1 while RUN; cleared on leaving CRASHED or on reset_round.
- States: IDLE (hold start position, frame_cnt=0, ignore crash) -> RUN when go=1. RUN: at move event, if crash_seen -> CRASHED without moving; else dir<=pending_dir, then step. CRASHED: position/dir frozen, crashed=1; exits only via reset_round or reset.
- Step clamp: new x limited to [0, 610], y to [0, 450] (640-30, 480-30); saturate, never wrap. Clamped move still pulses move_strobe.
- reset_round has priority over every other event in every state: next cycle x=START_X, y=START_Y, dir=START_DIR, pending_dir=START_DIR, IDLE, crash_seen=0.

## Timing
- Reset values: bike_addr = START_Y*640+START_X, bike_orient = delta(START_DIR), dir = START_DIR, crashed 0, move_strobe 0, state IDLE, frame_cnt 0, vs_q 1.
- Tick asserted in cycle N where iVS first sampled low; bike_addr, dir, bike_orient update at end of cycle N, visible cycle N+1; move_strobe high exactly cycle N+1.
- bike_orient always reflects current dir (updated same edge as dir).
- crashed rises cycle after the move event that detects crash_seen.
- go and tick in same cycle from IDLE: enter RUN only; first move counted from next tick.
- Async reset mid-move: all registers return to reset values immediately.

## Configuration
- BIKE_BOOST_EN: when defined, adds input boost (1b); while boost=1 at move event, step is 2*STEP and bike_orient reports the doubled delta. When undefined, no boost port; step is always STEP.

## Test plan
- Reset, go=1, defaults, 3 iVS falling edges -> bike_addr 64100 -> 64102 -> 64104 -> 64106, move_strobe once per tick, bike_orient = 2.
- dir_req=4'b1000 between ticks from right -> next move: dir=0, bike_addr decreases by 1280, bike_orient = -1280 (32'hFFFFFB00).
- Moving right, dir_req=4'b0010 (left) -> ignored; dir stays 3, continues +2.
- START_X=609, right -> x clamps at 610 and holds on later moves, move_strobe still pulses.
- crash pulse 1 cycle mid-frame -> next move event: no position change, crashed=1; further ticks frozen; reset_round -> IDLE, start address, crashed 0.
- FRAMES_PER_MOVE=3 -> position changes on every 3rd tick only.

Source files
------------

// File: rtl/bike_motion_engine_if.sv
// Bus between one bike_motion_engine and its controller/renderer side.
// With BIKE_BOOST_EN defined the bus carries an extra boost request.
interface bike_motion_engine_if;
  logic        iVS;
  logic        go;
  logic        reset_round;
  logic [3:0]  dir_req;
  logic        crash;
  logic [31:0] bike_addr;
  logic [31:0] bike_orient;
  logic [1:0]  dir;
  logic        crashed;
  logic        move_strobe;
`ifdef BIKE_BOOST_EN
  logic        boost;

  modport master (
    output iVS, go, reset_round, dir_req, crash, boost,
    input  bike_addr, bike_orient, dir, crashed, move_strobe
  );
  modport slave (
    input  iVS, go, reset_round, dir_req, crash, boost,
    output bike_addr, bike_orient, dir, crashed, move_strobe
  );
`else
  modport master (
    output iVS, go, reset_round, dir_req, crash,
    input  bike_addr, bike_orient, dir, crashed, move_strobe
  );
  modport slave (
    input  iVS, go, reset_round, dir_req, crash,
    output bike_addr, bike_orient, dir, crashed, move_strobe
  );
`endif
endinterface

// File: rtl/bike_motion_engine.sv
// Per-player bike movement: frame-paced stepping, turn filtering, edge clamp, crash freeze.
// Optional macro BIKE_BOOST_EN adds a boost input that doubles the step on move events.
//
// state      | meaning
// ST_IDLE    | parked at start position, waiting for go
// ST_RUN     | moving one step per FRAMES_PER_MOVE frames
// ST_CRASHED | frozen after a crash, waiting for reset_round
module bike_motion_engine #(
  parameter logic [18:0] START_X         = 19'd100,
  parameter logic [18:0] START_Y         = 19'd100,
  parameter logic [1:0]  START_DIR       = 2'd3,
  parameter logic [3:0]  STEP            = 4'd2,
  parameter logic [3:0]  FRAMES_PER_MOVE = 4'd1
) (
  input logic                 iVGA_CLK,
  input logic                 iRST_n,
  bike_motion_engine_if.slave bus
);

  localparam logic [9:0]  X_MAX = 10'd610;
  localparam logic [8:0]  Y_MAX = 9'd450;
  localparam logic [1:0]  DIR_UP    = 2'd0;
  localparam logic [1:0]  DIR_DOWN  = 2'd1;
  localparam logic [1:0]  DIR_LEFT  = 2'd2;
  localparam logic [31:0] START_ADDR = 32'(START_Y[8:0]) * 32'd640 + 32'(START_X[9:0]);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_CRASHED = 2'd2
  } state_t;

  function automatic logic [31:0] delta(input logic [1:0] d, input logic [4:0] st);
    logic [31:0] row_v;
    row_v = 32'(st) * 32'd640;
    case (d)
      DIR_UP:   delta = -row_v;
      DIR_DOWN: delta = row_v;
      DIR_LEFT: delta = -(32'(st));
      default:  delta = 32'(st);
    endcase
  endfunction

  state_t      state_q, state_n;
  logic        vs_q;
  logic        tick;
  logic [3:0]  frame_cnt_q;
  logic        last_frame;
  logic [9:0]  x_q, x_n;
  logic [8:0]  y_q, y_n;
  logic [1:0]  dir_q;
  logic [1:0]  pending_q;
  logic        crash_seen_q;
  logic [31:0] addr_q, addr_n;
  logic [31:0] orient_q;
  logic        strobe_q;
  logic        do_step;
  logic [1:0]  req_dir;
  logic        req_valid;
  logic        req_accept;
  logic [4:0]  step_sz;
  logic [10:0] sum_x;
  logic [9:0]  sum_y;

`ifdef BIKE_BOOST_EN
  assign step_sz = bus.boost ? {STEP, 1'b0} : {1'b0, STEP};
`else
  assign step_sz = {1'b0, STEP};
`endif

  assign tick       = vs_q & ~bus.iVS;
  assign last_frame = (frame_cnt_q == (FRAMES_PER_MOVE - 4'd1));

  // Requests that reverse or repeat the current heading never reach pending_q.
  always_comb begin
    req_dir   = pending_q;
    req_valid = 1'b1;
    casez (bus.dir_req)
      4'b1???: req_dir = 2'd0;
      4'b01??: req_dir = 2'd1;
      4'b001?: req_dir = 2'd2;
      4'b0001: req_dir = 2'd3;
      default: req_valid = 1'b0;
    endcase
    req_accept = req_valid && (req_dir != dir_q) && (req_dir != (dir_q ^ 2'd1));
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) state_q <= ST_IDLE;
    else         state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    do_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.go) state_n = ST_RUN;
      end
      ST_RUN: begin
        if (tick && last_frame) begin
          if (crash_seen_q) state_n = ST_CRASHED;
          else              do_step = 1'b1;
        end
      end
      ST_CRASHED: state_n = ST_CRASHED;
      default:    state_n = ST_IDLE;
    endcase
    if (bus.reset_round) begin
      state_n = ST_IDLE;
      do_step = 1'b0;
    end
  end

  // Candidate position one step along pending_q, saturated at the playfield edges.
  always_comb begin
    x_n   = x_q;
    y_n   = y_q;
    sum_x = {1'b0, x_q} + {6'd0, step_sz};
    sum_y = {1'b0, y_q} + {5'd0, step_sz};
    case (pending_q)
      DIR_UP:   y_n = (y_q < {4'd0, step_sz}) ? 9'd0 : (y_q - {4'd0, step_sz});
      DIR_DOWN: y_n = (sum_y > {1'b0, Y_MAX}) ? Y_MAX : sum_y[8:0];
      DIR_LEFT: x_n = (x_q < {5'd0, step_sz}) ? 10'd0 : (x_q - {5'd0, step_sz});
      default:  x_n = (sum_x > {1'b0, X_MAX}) ? X_MAX : sum_x[9:0];
    endcase
    addr_n = 32'(y_n) * 32'd640 + 32'(x_n);
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      vs_q         <= 1'b1;
      frame_cnt_q  <= 4'd0;
      x_q          <= START_X[9:0];
      y_q          <= START_Y[8:0];
      dir_q        <= START_DIR;
      pending_q    <= START_DIR;
      crash_seen_q <= 1'b0;
      addr_q       <= START_ADDR;
      orient_q     <= delta(START_DIR, {1'b0, STEP});
      strobe_q     <= 1'b0;
    end else begin
      vs_q     <= bus.iVS;
      strobe_q <= 1'b0;
      if (bus.reset_round) begin
        frame_cnt_q  <= 4'd0;
        x_q          <= START_X[9:0];
        y_q          <= START_Y[8:0];
        dir_q        <= START_DIR;
        pending_q    <= START_DIR;
        crash_seen_q <= 1'b0;
        addr_q       <= START_ADDR;
        orient_q     <= delta(START_DIR, {1'b0, STEP});
      end else begin
        if (req_accept) pending_q <= req_dir;
        if ((state_q == ST_RUN) && bus.crash) crash_seen_q <= 1'b1;
        if (state_q != ST_RUN) frame_cnt_q <= 4'd0;
        else if (tick)         frame_cnt_q <= last_frame ? 4'd0 : (frame_cnt_q + 4'd1);
        if (do_step) begin
          dir_q    <= pending_q;
          x_q      <= x_n;
          y_q      <= y_n;
          addr_q   <= addr_n;
          orient_q <= delta(pending_q, step_sz);
          strobe_q <= 1'b1;
        end
      end
    end
  end

  assign bus.bike_addr   = addr_q;
  assign bus.bike_orient = orient_q;
  assign bus.dir         = dir_q;
  assign bus.crashed     = (state_q == ST_CRASHED);
  assign bus.move_strobe = strobe_q;

endmodule

// File: tb/tb_bike_motion_engine.sv
// Bench for bike_motion_engine: three parameterisations share one stimulus stream
// and are checked against a behavioural model, a vector table and directed sequences.
module tb_bike_motion_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vs = 1'b1;
  logic       go = 1'b0;
  logic       rr = 1'b0;
  logic       crash = 1'b0;
  logic [3:0] dir_req = 4'd0;

  always #5 clk = ~clk;

  bike_motion_engine_if bus_a ();
  bike_motion_engine_if bus_b ();
  bike_motion_engine_if bus_c ();

  assign bus_a.iVS = vs;  assign bus_a.go = go;  assign bus_a.reset_round = rr;
  assign bus_a.dir_req = dir_req;  assign bus_a.crash = crash;
  assign bus_b.iVS = vs;  assign bus_b.go = go;  assign bus_b.reset_round = rr;
  assign bus_b.dir_req = dir_req;  assign bus_b.crash = crash;
  assign bus_c.iVS = vs;  assign bus_c.go = go;  assign bus_c.reset_round = rr;
  assign bus_c.dir_req = dir_req;  assign bus_c.crash = crash;
`ifdef BIKE_BOOST_EN
  assign bus_a.boost = 1'b0;  assign bus_b.boost = 1'b0;  assign bus_c.boost = 1'b0;
`endif

  bike_motion_engine u_a (.iVGA_CLK(clk), .iRST_n(rst_n), .bus(bus_a.slave));
  bike_motion_engine #(.START_X(19'd609)) u_b (.iVGA_CLK(clk), .iRST_n(rst_n), .bus(bus_b.slave));
  bike_motion_engine #(.FRAMES_PER_MOVE(4'd3)) u_c (.iVGA_CLK(clk), .iRST_n(rst_n), .bus(bus_c.slave));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: per-instance game state in plain integers.
  int psx[3]  = '{100, 609, 100};
  int psy[3]  = '{100, 100, 100};
  int psd[3]  = '{3, 3, 3};
  int pstep[3] = '{2, 2, 2};
  int pfpm[3] = '{1, 1, 3};
  int mx[3], my[3], mdir[3], mpend[3], mmode[3], mfc[3], mcs[3], mstb[3], mvsp[3];

  function automatic int delta(input int d, input int st);
    case (d)
      0:       return -640 * st;
      1:       return 640 * st;
      2:       return -st;
      default: return st;
    endcase
  endfunction

  function automatic int imin(input int a, input int b); return (a < b) ? a : b; endfunction
  function automatic int imax(input int a, input int b); return (a > b) ? a : b; endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mx[i] = psx[i];  my[i] = psy[i];  mdir[i] = psd[i];  mpend[i] = psd[i];
      mmode[i] = 0;  mfc[i] = 0;  mcs[i] = 0;  mstb[i] = 0;  mvsp[i] = 1;
    end
  endtask

  task automatic model_clock();
    for (int i = 0; i < 3; i++) begin
      bit tk;
      int r;
      int np;
      tk = (mvsp[i] == 1) && (vs == 1'b0);
      mvsp[i] = int'(vs);
      mstb[i] = 0;
      if (rr) begin
        mx[i] = psx[i];  my[i] = psy[i];  mdir[i] = psd[i];  mpend[i] = psd[i];
        mmode[i] = 0;  mfc[i] = 0;  mcs[i] = 0;
        continue;
      end
      np = mpend[i];
      if (dir_req != 4'd0) begin
        if (dir_req[3])      r = 0;
        else if (dir_req[2]) r = 1;
        else if (dir_req[1]) r = 2;
        else                 r = 3;
        if (r != mdir[i] && r != (mdir[i] ^ 1)) np = r;
      end
      if (mmode[i] == 0) begin
        mfc[i] = 0;
        if (go) mmode[i] = 1;
      end else if (mmode[i] == 1) begin
        if (tk) begin
          if (mfc[i] == pfpm[i] - 1) begin
            mfc[i] = 0;
            if (mcs[i] != 0) mmode[i] = 2;
            else begin
              mdir[i] = mpend[i];
              case (mdir[i])
                0:       my[i] = imax(0, my[i] - pstep[i]);
                1:       my[i] = imin(450, my[i] + pstep[i]);
                2:       mx[i] = imax(0, mx[i] - pstep[i]);
                default: mx[i] = imin(610, mx[i] + pstep[i]);
              endcase
              mstb[i] = 1;
            end
          end else mfc[i]++;
        end
        if (crash) mcs[i] = 1;
      end
      mpend[i] = np;
    end
  endtask

  task automatic compare_one(input int i, input logic [31:0] addr, input logic [31:0] orient,
                             input logic [1:0] d, input logic cr, input logic stb);
    check($sformatf("addr[%0d]", i), addr, 32'(my[i] * 640 + mx[i]));
    check($sformatf("orient[%0d]", i), orient, 32'(delta(mdir[i], pstep[i])));
    check($sformatf("dir[%0d]", i), 32'(d), 32'(mdir[i]));
    check($sformatf("crashed[%0d]", i), 32'(cr), 32'(mmode[i] == 2));
    check($sformatf("strobe[%0d]", i), 32'(stb), 32'(mstb[i]));
  endtask

  task automatic compare_all();
    compare_one(0, bus_a.bike_addr, bus_a.bike_orient, bus_a.dir, bus_a.crashed, bus_a.move_strobe);
    compare_one(1, bus_b.bike_addr, bus_b.bike_orient, bus_b.dir, bus_b.crashed, bus_b.move_strobe);
    compare_one(2, bus_c.bike_addr, bus_c.bike_orient, bus_c.dir, bus_c.crashed, bus_c.move_strobe);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_clock();
    #1;
    compare_all();
  endtask

  typedef struct {
    logic        vs, go, rr, crash;
    logic [3:0]  req;
    logic [31:0] addr, orient;
    logic [1:0]  dir;
    logic        crashed, stb;
  } vec_t;

  vec_t vt[14];

  initial begin
    vt[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 32'd64100, 32'd2, 2'd3, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'd64102, 32'd2, 2'd3, 1'b0, 1'b1};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'd64102, 32'd2, 2'd3, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 32'd64102, 32'd2, 2'd3, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'd64104, 32'd2, 2'd3, 1'b0, 1'b1};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, 32'd64104, 32'd2, 2'd3, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'd62824, 32'hFFFFFB00, 2'd0, 1'b0, 1'b1};
    vt[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 32'd62824, 32'hFFFFFB00, 2'd0, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'd61544, 32'hFFFFFB00, 2'd0, 1'b0, 1'b1};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 32'd61544, 32'hFFFFFB00, 2'd0, 1'b0, 1'b0};
    vt[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'd61544, 32'hFFFFFB00, 2'd0, 1'b1, 1'b0};
    vt[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 32'd61544, 32'hFFFFFB00, 2'd0, 1'b1, 1'b0};
    vt[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'd61544, 32'hFFFFFB00, 2'd0, 1'b1, 1'b0};
    vt[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 32'd64100, 32'd2, 2'd3, 1'b0, 1'b0};

    // Reset values
    #12;
    model_reset();
    check("rst_addr", bus_a.bike_addr, 32'd64100);
    check("rst_orient", bus_a.bike_orient, 32'd2);
    check("rst_strobe", 32'(bus_a.move_strobe), 32'd0);
    compare_all();
    rst_n = 1'b1;

    // Vector table on the default instance
    for (int k = 0; k < 14; k++) begin
      vs = vt[k].vs;  go = vt[k].go;  rr = vt[k].rr;  crash = vt[k].crash;  dir_req = vt[k].req;
      cyc();
      check($sformatf("vec%0d_addr", k), bus_a.bike_addr, vt[k].addr);
      check($sformatf("vec%0d_orient", k), bus_a.bike_orient, vt[k].orient);
      check($sformatf("vec%0d_dir", k), 32'(bus_a.dir), 32'(vt[k].dir));
      check($sformatf("vec%0d_crashed", k), 32'(bus_a.crashed), 32'(vt[k].crashed));
      check($sformatf("vec%0d_strobe", k), 32'(bus_a.move_strobe), 32'(vt[k].stb));
    end

    // go together with a tick only enters RUN; then reversal ignored, clamp, slow pacing
    rr = 1'b0;  go = 1'b0;  crash = 1'b0;  dir_req = 4'd0;  vs = 1'b1;
    cyc();
    vs = 1'b0;  go = 1'b1;
    cyc();
    check("go_tick_strobe", 32'(bus_a.move_strobe), 32'd0);
    check("go_tick_addr", bus_a.bike_addr, 32'd64100);
    go = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      vs = 1'b1;  dir_req = (k == 2) ? 4'b0010 : 4'b0000;
      cyc();
      vs = 1'b0;  dir_req = 4'b0000;
      cyc();
      check($sformatf("seq%0d_a_addr", k), bus_a.bike_addr, 32'(64100 + 2 * k));
      check($sformatf("seq%0d_a_dir", k), 32'(bus_a.dir), 32'd3);
      check($sformatf("seq%0d_b_addr", k), bus_b.bike_addr, 32'd64610);
      check($sformatf("seq%0d_b_strobe", k), 32'(bus_b.move_strobe), 32'd1);
      check($sformatf("seq%0d_c_strobe", k), 32'(bus_c.move_strobe), 32'((k % 3) == 0));
      check($sformatf("seq%0d_c_addr", k), bus_c.bike_addr, 32'(64100 + 2 * (k / 3)));
    end

    // Randomised play against the model
    for (int n = 0; n < 3000; n++) begin
      vs      = ($urandom_range(0, 7) != 0);
      go      = ($urandom_range(0, 9) == 0);
      rr      = ($urandom_range(0, 149) == 0);
      crash   = ($urandom_range(0, 79) == 0);
      dir_req = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      cyc();
    end

    // Asynchronous reset between edges
    vs = 1'b1;  go = 1'b1;  rr = 1'b0;  crash = 1'b0;  dir_req = 4'd0;
    cyc();
    vs = 1'b0;
    cyc();
    rst_n = 1'b0;
    #2;
    model_reset();
    check("async_rst_addr", bus_a.bike_addr, 32'd64100);
    check("async_rst_dir", 32'(bus_a.dir), 32'd3);
    compare_all();
    #1;
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      vs = n[0];
      go = 1'b1;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
